// File: rtl/mbm_pkg.sv
// mbm_pkg: shared widths, Booth digit encoding, sign-extension constant and carry-save helper
package mbm_pkg;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int NUM_PP = 8;
  localparam int PP_W   = OP_W + 2;
  // -sum(2^(17+2k)) mod 2^32: cancels the +2^17 bias of each inverted-sign partial product
  localparam logic [PROD_W-1:0] SE_CONST = 32'h5556_0000;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_t;
  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;
  function automatic booth_t booth_enc(input logic [2:0] y);
    booth_enc.neg = y[2] & ~(y[1] & y[0]);
    booth_enc.one = y[1] ^ y[0];
    booth_enc.two = (y[2] & ~y[1] & ~y[0]) | (~y[2] & y[1] & y[0]);
  endfunction
  function automatic csa_t csa(input logic [PROD_W-1:0] a, input logic [PROD_W-1:0] b, input logic [PROD_W-1:0] c);
    csa.s = a ^ b ^ c;
    csa.c = ((a & b) | (a & c) | (b & c)) << 1;
  endfunction
endpackage

// File: rtl/mbm_direct_core_booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth digit, selects 0/+-M/+-2M as one's complement plus neg flag
module booth_pp_gen
  import mbm_pkg::*;
(
  input  logic [2:0]      slice,
  input  logic [OP_W:0]   m,
  output logic [PP_W-1:0] pp,
  output logic            neg
);
  booth_t dig;
  logic [PP_W-1:0] sel;
  always_comb begin
    dig = booth_enc(slice);
    sel = dig.two ? {m, 1'b0} : dig.one ? {m[OP_W], m} : '0;
    neg = dig.neg;
    pp  = sel ^ {PP_W{dig.neg}};
  end
endmodule

// File: rtl/mbm_direct_core.sv
// mbm_direct_core: exact signed 16x16 radix-4 Booth multiplier, combinational CSA tree plus CPA
module mbm_direct_core
  import mbm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [OP_W-1:0]   multplr,
  input  logic signed [OP_W-1:0]   multplcnd,
  output logic signed [PROD_W-1:0] prod
);
  logic [OP_W:0]       y_ext;
  logic [OP_W:0]       m;
  logic [PP_W-1:0]     pp [NUM_PP];
  logic [NUM_PP-1:0]   neg;
  logic [PROD_W-1:0]   row [NUM_PP+1];
  logic [PROD_W-1:0]   corr;
  csa_t l1a, l1b, l1c, l2a, l2b, l3, l4;
  logic unused_ok;
  assign unused_ok = clk ^ rst;
  assign y_ext = {multplr, 1'b0};
  assign m     = {multplcnd[OP_W-1], multplcnd};
  genvar k;
  for (k = 0; k < NUM_PP; k++) begin : g_pp
    booth_pp_gen u_pp (
      .slice (y_ext[2*k+2:2*k]),
      .m     (m),
      .pp    (pp[k]),
      .neg   (neg[k])
    );
    // inverted sign bit replaces sign extension; SE_CONST removes the bias
    assign row[k] = {{(PROD_W-PP_W){1'b0}}, ~pp[k][PP_W-1], pp[k][PP_W-2:0]} << (2*k);
  end
  always_comb begin
    corr = SE_CONST;
    for (int i = 0; i < NUM_PP; i++) corr[2*i] = neg[i];
  end
  assign row[NUM_PP] = corr;
  always_comb begin
    l1a  = csa(row[0], row[1], row[2]);
    l1b  = csa(row[3], row[4], row[5]);
    l1c  = csa(row[6], row[7], row[8]);
    l2a  = csa(l1a.s, l1a.c, l1b.s);
    l2b  = csa(l1b.c, l1c.s, l1c.c);
    l3   = csa(l2a.s, l2a.c, l2b.s);
    l4   = csa(l3.s, l3.c, l2b.c);
    prod = l4.s + l4.c;
  end
endmodule

// File: tb/tb_mbm_direct_core.sv
// tb_mbm_direct_core: directed and random checks of the Booth multiplier against signed '*'
module tb_mbm_direct_core;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] multplr = '0;
  logic signed [15:0] multplcnd = '0;
  logic signed [31:0] prod;
  int n_vec = 0;
  int n_err = 0;
  mbm_direct_core dut (
    .clk       (clk),
    .rst       (rst),
    .multplr   (multplr),
    .multplcnd (multplcnd),
    .prod      (prod)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s a=%0d b=%0d got=%0d exp=%0d", tag, multplr, multplcnd, $signed(got), $signed(exp));
    end
  endtask
  task automatic apply(input string tag, input logic signed [15:0] a, input logic signed [15:0] b, input int exp);
    multplr = a;
    multplcnd = b;
    #5;
    chk(tag, prod, exp);
  endtask
  initial begin
    for (int i = 1; i <= 10; i++) begin
      multplr = 16'(56 * i);
      multplcnd = 16'(-4 * i);
      #5;
      chk("sweep", prod, -224 * i * i);
      chk("sweep_beh", prod, int'(multplr) * int'(multplcnd));
    end
    apply("min_min", -16'sd32768, -16'sd32768, 1073741824);
    apply("min_max", -16'sd32768, 16'sd32767, -1073709056);
    apply("max_max", 16'sd32767, 16'sd32767, 1073676289);
    apply("zero_m1", 16'sd0, -16'sd1, 0);
    apply("m1_m1", -16'sd1, -16'sd1, 1);
    apply("b_aaaa", 16'shAAAA, 16'sd12345, -269688870);
    apply("b_5555", 16'sh5555, 16'sd12345, 269676525);
    apply("b_ffff", 16'shFFFF, 16'sd12345, -12345);
    apply("b_8000", 16'sh8000, 16'sd12345, -404520960);
    @(negedge clk);
    rst = 1'b1;
    multplr = 16'sd100;
    multplcnd = -16'sd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", prod, -700);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after", prod, -700);
    for (int i = 0; i < 10000; i++) begin
      multplr = 16'($urandom);
      multplcnd = 16'($urandom);
      #2;
      chk("random", prod, int'(multplr) * int'(multplcnd));
      #3;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
